// File: rtl/rand_vec_gen_if.sv
// Handshake/control bundle between the stimulus sequencer (master) and rand_vec_gen (slave).
// Carries the optional ch_mask signal when RVG_CH_MASK_EN is defined.
interface rand_vec_gen_if #(
   parameter int N_CH  = 6,
   parameter int CH_W  = 2,
   parameter int CNT_W = 16
);
   localparam int VEC_W = N_CH * CH_W;

   logic             seed_load;
   logic [31:0]      seed_in;
   logic             start;
   logic [CNT_W-1:0] count_in;
   logic             stop;
   logic [VEC_W-1:0] vec_data;
   logic             vec_valid;
   logic             vec_ready;
   logic [CNT_W-1:0] vec_idx;
   logic             busy;
   logic             done;
`ifdef RVG_CH_MASK_EN
   logic [N_CH-1:0]  ch_mask;
`endif

   modport master (
      output seed_load, seed_in, start, count_in, stop, vec_ready,
      input  vec_data, vec_valid, vec_idx, busy, done
`ifdef RVG_CH_MASK_EN
      , output ch_mask
`endif
   );

   modport slave (
      input  seed_load, seed_in, start, count_in, stop, vec_ready,
      output vec_data, vec_valid, vec_idx, busy, done
`ifdef RVG_CH_MASK_EN
      , input ch_mask
`endif
   );
endinterface

// File: rtl/rand_vec_gen.sv
// Seedable 32-bit Galois-LFSR stimulus source with burst counting and valid/ready output.
// Optional per-channel output masking is enabled by defining RVG_CH_MASK_EN.
module rand_vec_gen #(
   parameter int          N_CH     = 6,
   parameter int          CH_W     = 2,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] DEF_SEED = 32'h0000_0001
) (
   input logic           clk,
   input logic           rst_n,
   rand_vec_gen_if.slave bus
);
   localparam int          VEC_W     = N_CH * CH_W;
   localparam int          K         = (VEC_W + 31) / 32;
   localparam int          ACC_W     = K * 32;
   localparam int          WCNT_W    = (K > 1) ? $clog2(K) : 1;
   localparam logic [31:0] TAP_MASK  = 32'h8020_0003;
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_lfsr;
   logic [31:0]      w_lfsr_step;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [WCNT_W-1:0] r_word;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_idx;
   logic [VEC_W-1:0] r_vec_data;
   logic [VEC_W-1:0] w_vec_masked;
   logic             r_vec_valid;
   logic             r_done;

   logic w_step;
   logic w_last_word;
   logic w_last_vec;
   logic w_handshake;
   logic w_seed_ld;
   logic w_burst_start;
   logic w_emit;
   logic w_advance;
   logic w_end;

`ifdef RVG_CH_MASK_EN
   logic [N_CH-1:0] r_mask;
`endif

   assign w_step      = (r_state == S_FILL);
   assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAP_MASK) : (r_lfsr >> 1);
   assign w_last_word = (r_word == LAST_WORD);
   assign w_handshake = r_vec_valid && bus.vec_ready;
   assign w_last_vec  = (r_count != '0) && (r_idx == r_count - 1'b1);

   // Drop the freshly stepped LFSR word into its slice of the vector being assembled.
   always_comb begin
      w_acc_nxt = r_acc;
      for (int k = 0; k < K; k++) begin
         if (r_word == WCNT_W'(k)) w_acc_nxt[k*32 +: 32] = w_lfsr_step;
      end
   end

`ifdef RVG_CH_MASK_EN
   always_comb begin
      w_vec_masked = w_acc_nxt[VEC_W-1:0];
      for (int c = 0; c < N_CH; c++) begin
         if (!r_mask[c]) w_vec_masked[c*CH_W +: CH_W] = '0;
      end
   end
`else
   assign w_vec_masked = w_acc_nxt[VEC_W-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every signal this block drives gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_state_nxt   = r_state;
      w_seed_ld     = 1'b0;
      w_burst_start = 1'b0;
      w_emit        = 1'b0;
      w_advance     = 1'b0;
      w_end         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_seed_ld = bus.seed_load;
            if (bus.start) begin
               w_burst_start = 1'b1;
               w_state_nxt   = S_FILL;
            end
         end
         S_FILL: begin
            if (bus.stop) begin
               w_end       = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_last_word) begin
               w_emit      = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            // A handshake coinciding with stop still transfers; the burst simply ends.
            if (bus.stop || (w_handshake && w_last_vec)) begin
               w_end       = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_handshake) begin
               w_advance   = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr      <= DEF_SEED;
         r_acc       <= '0;
         r_word      <= '0;
         r_count     <= '0;
         r_idx       <= '0;
         r_vec_data  <= '0;
         r_vec_valid <= 1'b0;
         r_done      <= 1'b0;
`ifdef RVG_CH_MASK_EN
         r_mask      <= '1;
`endif
      end else begin
         r_done <= w_end;

         if (w_seed_ld)   r_lfsr <= (bus.seed_in == '0) ? DEF_SEED : bus.seed_in;
         else if (w_step) r_lfsr <= w_lfsr_step;

         if (w_burst_start) begin
            r_word <= '0;
         end else if (w_step) begin
            r_acc  <= w_acc_nxt;
            r_word <= w_last_word ? '0 : r_word + 1'b1;
         end

         if (w_burst_start) begin
            r_count <= bus.count_in;
            r_idx   <= '0;
`ifdef RVG_CH_MASK_EN
            r_mask  <= bus.ch_mask;
`endif
         end else if (w_advance) begin
            r_idx <= r_idx + 1'b1;
         end

         if (w_emit) begin
            r_vec_data  <= w_vec_masked;
            r_vec_valid <= 1'b1;
         end else if (w_end || w_advance) begin
            r_vec_valid <= 1'b0;
         end
      end
   end

   assign bus.vec_data  = r_vec_data;
   assign bus.vec_valid = r_vec_valid;
   assign bus.vec_idx   = r_idx;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;

endmodule

// File: tb/tb_rand_vec_gen.sv
// Self-checking bench for rand_vec_gen: a 4x8 instance (one LFSR word per vector) and a
// 20x2 instance (two words per vector), checked against a spec-level LFSR sequence model.
module tb_rand_vec_gen;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_lfsr_a;
   logic [31:0] m_lfsr_b;

   rand_vec_gen_if #(.N_CH(4),  .CH_W(8), .CNT_W(16)) ia ();
   rand_vec_gen_if #(.N_CH(20), .CH_W(2), .CNT_W(16)) ib ();

   rand_vec_gen #(.N_CH(4), .CH_W(8), .CNT_W(16), .DEF_SEED(32'h0000_0001)) dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ia.slave)
   );

   rand_vec_gen #(.N_CH(20), .CH_W(2), .CNT_W(16), .DEF_SEED(32'h0000_0001)) dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ib.slave)
   );

   typedef struct {
      logic [31:0] seed;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_rec_t;

   vec_rec_t tbl [4];

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   task automatic next_vec_a(output logic [31:0] v);
      m_lfsr_a = lfsr_next(m_lfsr_a);
      v = m_lfsr_a;
   endtask

   task automatic next_vec_b(output logic [39:0] v);
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = lfsr_next(m_lfsr_b);
      w1 = lfsr_next(w0);
      m_lfsr_b = w1;
      v = {w1[7:0], w0};
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid_a();
      int n = 0;
      while (!ia.vec_valid && n < 50) begin tick(); n++; end
      check("a_valid_wait", ia.vec_valid, 1);
   endtask

   task automatic wait_valid_b();
      int n = 0;
      while (!ib.vec_valid && n < 50) begin tick(); n++; end
      check("b_valid_wait", ib.vec_valid, 1);
   endtask

   task automatic burst_a(input bit do_seed, input logic [31:0] seed, input int count);
      logic [31:0] exp;
      if (do_seed) m_lfsr_a = (seed == 0) ? 32'h1 : seed;
      ia.seed_load = do_seed; ia.seed_in = seed; ia.count_in = 16'(count); ia.start = 1'b1;
      tick();
      ia.seed_load = 1'b0; ia.start = 1'b0;
      ia.count_in = 16'($urandom);
      for (int v = 0; v < count; v++) begin
         wait_valid_a();
         next_vec_a(exp);
         check("a_data", ia.vec_data, exp);
         check("a_idx", ia.vec_idx, v);
         while ($urandom_range(3) == 0) begin
            ia.vec_ready = 1'b0;
            tick();
            check("a_hold_data", ia.vec_data, exp);
         end
         ia.vec_ready = 1'b1;
         tick();
         ia.vec_ready = 1'b0;
      end
      check("a_done", ia.done, 1);
      check("a_idle", ia.busy, 0);
      tick();
   endtask

   task automatic burst_b(input bit do_seed, input logic [31:0] seed, input int count);
      logic [39:0] exp;
      if (do_seed) m_lfsr_b = (seed == 0) ? 32'h1 : seed;
      ib.seed_load = do_seed; ib.seed_in = seed; ib.count_in = 16'(count); ib.start = 1'b1;
      tick();
      ib.seed_load = 1'b0; ib.start = 1'b0;
      for (int v = 0; v < count; v++) begin
         wait_valid_b();
         next_vec_b(exp);
         check("b_data", ib.vec_data, exp);
         check("b_idx", ib.vec_idx, v);
         while ($urandom_range(3) == 0) begin
            ib.vec_ready = 1'b0;
            tick();
            check("b_hold_data", ib.vec_data, exp);
         end
         ib.vec_ready = 1'b1;
         tick();
         ib.vec_ready = 1'b0;
      end
      check("b_done", ib.done, 1);
      check("b_idle", ib.busy, 0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] ea;
      logic [39:0] eb;
      int          lat;

      tbl[0] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
      tbl[1] = '{32'h0000_0000, 32'h8020_0003, 32'hC030_0002};
      tbl[2] = '{32'h0000_0002, 32'h0000_0001, 32'h8020_0003};
      tbl[3] = '{32'hFFFF_FFFF, 32'hFFDF_FFFC, 32'h7FEF_FFFE};

      ia.seed_load = 0; ia.seed_in = 0; ia.start = 0; ia.count_in = 0; ia.stop = 0; ia.vec_ready = 0;
      ib.seed_load = 0; ib.seed_in = 0; ib.start = 0; ib.count_in = 0; ib.stop = 0; ib.vec_ready = 0;
`ifdef RVG_CH_MASK_EN
      ia.ch_mask = '1;
      ib.ch_mask = '1;
`endif

      // Reset state
      #22;
      check("rst_a_valid", ia.vec_valid, 0);
      check("rst_a_data", ia.vec_data, 0);
      check("rst_a_idx", ia.vec_idx, 0);
      check("rst_a_busy", ia.busy, 0);
      check("rst_b_done", ib.done, 0);
      check("rst_b_data", ib.vec_data, 0);
      rst_n = 1'b1;
      m_lfsr_a = 32'h1;
      m_lfsr_b = 32'h1;
      tick();

      // Wide vector from the reset seed: K=2, valid after 3 edges including the start edge
      ib.start = 1'b1; ib.count_in = 16'd1;
      tick();
      ib.start = 1'b0;
      lat = 1;
      while (!ib.vec_valid && lat < 20) begin tick(); lat++; end
      check("b_latency", lat, 3);
      check("b_wide_vec", ib.vec_data, {8'h02, 32'h8020_0003});
      m_lfsr_b = 32'hC030_0002;
      ib.vec_ready = 1'b1;
      tick();
      ib.vec_ready = 1'b0;
      check("b_wide_done", ib.done, 1);
      tick();
      check("b_wide_done_pulse", ib.done, 0);

      // Table-driven seeded two-vector bursts with ready tied high
      for (int i = 0; i < 4; i++) begin
         ia.seed_load = 1'b1; ia.seed_in = tbl[i].seed; ia.start = 1'b1; ia.count_in = 16'd2;
         ia.vec_ready = 1'b1;
         tick();
         ia.seed_load = 1'b0; ia.start = 1'b0;
         wait_valid_a();
         check($sformatf("tbl%0d_vec0", i), ia.vec_data, tbl[i].exp0);
         check($sformatf("tbl%0d_idx0", i), ia.vec_idx, 0);
         tick();
         wait_valid_a();
         check($sformatf("tbl%0d_vec1", i), ia.vec_data, tbl[i].exp1);
         check($sformatf("tbl%0d_idx1", i), ia.vec_idx, 1);
         tick();
         check($sformatf("tbl%0d_done", i), ia.done, 1);
         check($sformatf("tbl%0d_valid_drop", i), ia.vec_valid, 0);
         ia.vec_ready = 1'b0;
         tick();
         check($sformatf("tbl%0d_done_pulse", i), ia.done, 0);
         check($sformatf("tbl%0d_idle", i), ia.busy, 0);
         m_lfsr_a = tbl[i].exp1;
      end

      // Backpressure: five cycles of vec_ready low in HOLD
      ia.start = 1'b1; ia.count_in = 16'd1;
      tick();
      ia.start = 1'b0;
      wait_valid_a();
      next_vec_a(ea);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", ia.vec_valid, 1);
         check("bp_data", ia.vec_data, ea);
      end
      ia.vec_ready = 1'b1;
      tick();
      ia.vec_ready = 1'b0;
      check("bp_done", ia.done, 1);
      check("bp_valid_drop", ia.vec_valid, 0);
      tick();

      // Stop mid-FILL of a continuous burst; the LFSR stepped once and keeps its state
      ib.start = 1'b1; ib.count_in = 16'd0;
      tick();
      ib.start = 1'b0;
      check("stop_busy", ib.busy, 1);
      ib.stop = 1'b1;
      tick();
      ib.stop = 1'b0;
      m_lfsr_b = lfsr_next(m_lfsr_b);
      check("stop_done", ib.done, 1);
      check("stop_valid", ib.vec_valid, 0);
      check("stop_idle", ib.busy, 0);
      tick();
      check("stop_done_pulse", ib.done, 0);
      burst_b(1'b0, 32'h0, 1);

      // Continuous burst on A, then stop together with a handshake in HOLD
      ia.start = 1'b1; ia.count_in = 16'd0;
      tick();
      ia.start = 1'b0;
      for (int v = 0; v < 4; v++) begin
         wait_valid_a();
         next_vec_a(ea);
         check("cont_data", ia.vec_data, ea);
         check("cont_idx", ia.vec_idx, v);
         ia.vec_ready = 1'b1;
         tick();
         ia.vec_ready = 1'b0;
      end
      wait_valid_a();
      next_vec_a(ea);
      check("cont_last_data", ia.vec_data, ea);
      ia.vec_ready = 1'b1; ia.stop = 1'b1;
      tick();
      ia.vec_ready = 1'b0; ia.stop = 1'b0;
      check("cont_stop_done", ia.done, 1);
      check("cont_stop_valid", ia.vec_valid, 0);
      check("cont_stop_idle", ia.busy, 0);
      tick();
      burst_a(1'b0, 32'h0, 1);

`ifdef RVG_CH_MASK_EN
      ia.ch_mask = 4'b0101;
      ia.seed_load = 1'b1; ia.seed_in = 32'h1; ia.start = 1'b1; ia.count_in = 16'd1;
      tick();
      ia.seed_load = 1'b0; ia.start = 1'b0;
      ia.ch_mask = 4'b1111;
      wait_valid_a();
      check("mask_vec", ia.vec_data, 32'h0020_0003);
      ia.vec_ready = 1'b1;
      tick();
      ia.vec_ready = 1'b0;
      tick();
      m_lfsr_a = 32'h8020_0003;
`endif

      // Randomized bursts against the model
      for (int i = 0; i < 30; i++) begin
         logic [31:0] s;
         s = ($urandom_range(4) == 0) ? 32'h0 : $urandom;
         if (i % 2 == 0) burst_a($urandom_range(1) == 1, s, int'($urandom_range(1, 4)));
         else            burst_b($urandom_range(1) == 1, s, int'($urandom_range(1, 4)));
      end

      // Asynchronous reset while B holds a valid vector
      ib.start = 1'b1; ib.count_in = 16'd0;
      tick();
      ib.start = 1'b0;
      wait_valid_b();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", ib.vec_valid, 0);
      check("arst_data", ib.vec_data, 0);
      check("arst_idx", ib.vec_idx, 0);
      check("arst_busy", ib.busy, 0);
      check("arst_done", ib.done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_lfsr_a = 32'h1;
      m_lfsr_b = 32'h1;
      tick();
      burst_b(1'b0, 32'h0, 2);
      burst_a(1'b0, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rand_vec_gen.md
Name: rand_vec_gen

Overview:
- Parametrised random stimulus source that drives N_CH channels of CH_W bits each into a DUT under test.
- It generalises the fixed six-input random assignment to any channel count and width, using a seedable 32-bit LFSR.
- Adds burst counting, a valid/ready output handshake and a start/stop control FSM.
- Sits between the testbench sequencer and the DUT input bus.

Parameters:
- N_CH, 6, number of output channels.
- CH_W, 2, bits per channel.
- CNT_W, 16, width of the burst counter.
- DEF_SEED, 32'h0000_0001, LFSR value after reset; also substituted whenever a zero seed is loaded.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  loads seed_in into the LFSR; honoured only in IDLE.
- seed_in  in  32  seed value.
- start  in  1  begins a burst; honoured only in IDLE.
- count_in  in  CNT_W  vectors in the burst; 0 means continuous.
- stop  in  1  aborts a RUN burst.
- vec_data  out  N_CH*CH_W  channel c occupies bits [c*CH_W +: CH_W].
- vec_valid  out  1  vec_data is valid.
- vec_ready  in  1  consumer accepts the vector.
- vec_idx  out  CNT_W  index of the current vector within the burst, starting at 0.
- busy  out  1  high in FILL and HOLD.
- done  out  1  one-cycle pulse when a burst ends.

Behaviour:
- Widths: VEC_W = N_CH*CH_W; K = ceil(VEC_W/32).
- LFSR:
  - 32-bit Galois, right-shift, tap mask 32'h8020_0003.
  - One step: if lfsr[0] then lfsr = (lfsr>>1) ^ mask, else lfsr = lfsr>>1.
  - Exactly one step per cycle while in FILL; no step in any other state.
- Vector assembly:
  - Each vector is built from K consecutive post-step LFSR states.
  - The first state goes to bits [31:0], the next to [63:32], and so on; the result is truncated to VEC_W.
- Reset (async, rst_n low):
  - lfsr = DEF_SEED, state = IDLE.
  - vec_data = 0, vec_valid = 0, vec_idx = 0, busy = 0, done = 0.
- FSM states:
  - IDLE:
    - seed_load: lfsr = (seed_in==0) ? DEF_SEED : seed_in.
    - start: latch count_in, clear vec_idx, go to FILL.
    - If seed_load and start are both asserted, the seed is loaded first and the burst uses the new seed.
  - FILL:
    - Step K cycles, filling the word slices.
    - On the K-th step, register vec_data, assert vec_valid and go to HOLD.
  - HOLD:
    - vec_data and vec_valid are stable until vec_ready.
    - When vec_valid && vec_ready:
      - If count != 0 and vec_idx == count-1: drop vec_valid, pulse done, go to IDLE.
      - Otherwise: increment vec_idx (wraps at 2^CNT_W in continuous mode) and go to FILL.
- Latency: from start to the first vec_valid is K+1 cycles.
- Throughput: one vector per K+1 cycles with vec_ready tied high.
- stop:
  - Asserted in FILL or HOLD, it aborts next cycle: vec_valid = 0, done pulses, go to IDLE.
  - A vector handshaking in the same cycle as stop still counts as transferred.
  - LFSR state is retained, so a new start continues the sequence.
- start in FILL or HOLD is ignored; seed_load outside IDLE is ignored.
- vec_data holds its last value in IDLE.
- count_in changing during a burst has no effect.

Optional Feature:
- Macro: RVG_CH_MASK_EN.
- Defined:
  - Adds input ch_mask[N_CH-1:0], sampled on start.
  - Channels with a 0 mask bit output all-zero slices in vec_data.
  - The LFSR still advances identically, so the unmasked sequence is unchanged.
- Undefined: no ch_mask port; all channels are always driven.

Test Plan:
- Reset then seed check: reset, N_CH=4, CH_W=8, start with count_in=2, vec_ready=1.
  - First vector 32'h8020_0003; second vector 32'hC030_0002.
  - vec_idx 0 then 1; done pulses once, then IDLE.
- Zero seed: seed_load with seed_in=0, then start count 1 → same first vector 32'h8020_0003 (DEF_SEED substituted).
- Backpressure: vec_ready held low 5 cycles in HOLD.
  - vec_data and vec_valid stay stable, no LFSR step.
  - Accepted on the cycle vec_ready rises.
- Wide vector: N_CH=20, CH_W=2 (VEC_W=40, K=2), seed 1.
  - First vector: bits[31:0]=32'h8020_0003, bits[39:32]=8'h02.
  - vec_valid first asserted 3 cycles after start.
- Abort and async reset: stop mid-FILL in a continuous burst.
  - done pulses, IDLE, and the next start continues the LFSR sequence.
  - rst_n low mid-HOLD clears all outputs immediately (asynchronously).
- RVG_CH_MASK_EN: N_CH=4, CH_W=8, ch_mask=4'b0101, seed 1 → first vector 32'h0020_0003.
